// File: rtl/sr_bank_arbiter_if.sv
// Bus between two write requesters, the arbiter and an external gated SR latch bank.
// The shadow/shadow_vld signals exist only when SR_SHADOW_EN is defined.
interface sr_bank_arbiter_if;
   logic       a_req;
   logic       a_op;
   logic [2:0] a_idx;
   logic       a_ack;
   logic       b_req;
   logic       b_op;
   logic [2:0] b_idx;
   logic       b_ack;
   logic [7:0] latch_s;
   logic [7:0] latch_r;
   logic       latch_gate;
   logic       busy;
`ifdef SR_SHADOW_EN
   logic [7:0] shadow;
   logic [7:0] shadow_vld;
`endif

   modport master (
      output a_req, a_op, a_idx, b_req, b_op, b_idx,
      input  a_ack, b_ack, latch_s, latch_r, latch_gate, busy
`ifdef SR_SHADOW_EN
      , input shadow, shadow_vld
`endif
   );

   modport slave (
      input  a_req, a_op, a_idx, b_req, b_op, b_idx,
      output a_ack, b_ack, latch_s, latch_r, latch_gate, busy
`ifdef SR_SHADOW_EN
      , output shadow, shadow_vld
`endif
   );
endinterface

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter sequencing set/clear writes into a gated SR latch bank.
// Optional macro SR_SHADOW_EN adds a shadow copy of written latch values.
module sr_bank_arbiter #(
   parameter int unsigned GATE_CYCLES = 2
) (
   input logic            clk,
   input logic            rst,
   sr_bank_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, PULSE = 2'd2, HOLD = 2'd3} state_t;

   localparam logic [3:0] LAST_CNT = 4'(GATE_CYCLES - 1);

   state_t     state_r, next_state_s;
   logic       gnt_b_r, gnt_b_s;
   logic       op_r, op_s;
   logic [2:0] idx_r, idx_s;
   logic [3:0] cnt_r, cnt_s;
   logic       prio_b_r, prio_b_s;
   logic [7:0] latch_s_r, latch_s_s;
   logic [7:0] latch_r_r, latch_r_s;
   logic       gate_r, gate_s;
   logic       a_ack_r, a_ack_s;
   logic       b_ack_r, b_ack_s;
   logic       busy_r, busy_s;

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      onehot8 = 8'd1 << idx;
   endfunction

   // Next state, capture of the granted request and next registered output values
   always_comb begin
      next_state_s = state_r;
      gnt_b_s      = gnt_b_r;
      op_s         = op_r;
      idx_s        = idx_r;
      cnt_s        = cnt_r;
      prio_b_s     = prio_b_r;
      case (state_r)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               next_state_s = SETUP;
               gnt_b_s      = bus.b_req && (!bus.a_req || prio_b_r);
               op_s         = gnt_b_s ? bus.b_op : bus.a_op;
               idx_s        = gnt_b_s ? bus.b_idx : bus.a_idx;
               prio_b_s     = !gnt_b_s;
            end else begin
               next_state_s = IDLE;
            end
         end
         SETUP: begin
            next_state_s = PULSE;
            cnt_s        = 4'd0;
         end
         PULSE: begin
            if (cnt_r == LAST_CNT) begin
               next_state_s = HOLD;
            end else begin
               cnt_s = cnt_r + 4'd1;
            end
         end
         HOLD: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase

      // Outputs are registered, so they are derived from the state being entered
      busy_s    = (next_state_s != IDLE);
      latch_s_s = (busy_s && op_s)  ? onehot8(idx_s) : 8'd0;
      latch_r_s = (busy_s && !op_s) ? onehot8(idx_s) : 8'd0;
      gate_s    = (next_state_s == PULSE);
      a_ack_s   = (next_state_s == HOLD) && !gnt_b_s;
      b_ack_s   = (next_state_s == HOLD) && gnt_b_s;
   end

   // State, captured transaction and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         gnt_b_r   <= 1'b0;
         op_r      <= 1'b0;
         idx_r     <= 3'd0;
         cnt_r     <= 4'd0;
         prio_b_r  <= 1'b0;
         latch_s_r <= 8'd0;
         latch_r_r <= 8'd0;
         gate_r    <= 1'b0;
         a_ack_r   <= 1'b0;
         b_ack_r   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         gnt_b_r   <= gnt_b_s;
         op_r      <= op_s;
         idx_r     <= idx_s;
         cnt_r     <= cnt_s;
         prio_b_r  <= prio_b_s;
         latch_s_r <= latch_s_s;
         latch_r_r <= latch_r_s;
         gate_r    <= gate_s;
         a_ack_r   <= a_ack_s;
         b_ack_r   <= b_ack_s;
         busy_r    <= busy_s;
      end
   end

   assign bus.latch_s    = latch_s_r;
   assign bus.latch_r    = latch_r_r;
   assign bus.latch_gate = gate_r;
   assign bus.a_ack      = a_ack_r;
   assign bus.b_ack      = b_ack_r;
   assign bus.busy       = busy_r;

`ifdef SR_SHADOW_EN
   logic [7:0] shadow_r;
   logic [7:0] shadow_vld_r;

   // Shadow copy is written at the end of the HOLD cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_r     <= 8'd0;
         shadow_vld_r <= 8'd0;
      end else if (state_r == HOLD) begin
         shadow_r[idx_r]     <= op_r;
         shadow_vld_r[idx_r] <= 1'b1;
      end else begin
         shadow_r     <= shadow_r;
         shadow_vld_r <= shadow_vld_r;
      end
   end

   assign bus.shadow     = shadow_r;
   assign bus.shadow_vld = shadow_vld_r;
`else
   // No shadow state in this build.
`endif
endmodule
